// File: rtl/alarm_scheduler_pkg.sv
// Shared definitions for the alarm scheduler: FSM state encodings, default
// constants and the slot-index width helper.
package alarm_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } alarm_state_e;

    localparam int DEF_NUM_ALARMS   = 4;
    localparam int DEF_TIME_W       = 12;
    localparam int DEF_RING_TIMEOUT = 60;
    localparam int DEF_SNOOZE_TICKS = 300;
    localparam int DEF_MAX_SNOOZE   = 3;

    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_scheduler_slot_bank.sv
// Alarm slot storage: write port, one-shot armed bits and per-slot time
// compare producing the hit vector on each 1 s tick.
module alarm_scheduler_slot_bank
    import alarm_scheduler_pkg::*;
#(
    parameter int NUM_ALARMS = DEF_NUM_ALARMS,
    parameter int TIME_W     = DEF_TIME_W,
    parameter int IDX_W      = calc_idx_w(DEF_NUM_ALARMS)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  tick_i,
    input  logic [TIME_W-1:0]     cur_time_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [TIME_W-1:0]     wr_time_i,
    input  logic                  wr_arm_i,
    output logic                  wr_ok_o,
    output logic [NUM_ALARMS-1:0] armed_o,
    output logic [NUM_ALARMS-1:0] hit_o
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_ALARMS);

    logic [TIME_W-1:0]     slot_time_q [NUM_ALARMS];
    logic [TIME_W-1:0]     slot_time_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed_q;
    logic [NUM_ALARMS-1:0] armed_d;
    logic [NUM_ALARMS-1:0] hit_s;
    logic                  wr_ok_s;

    assign wr_ok_s = wr_en_i && ({1'b0, wr_idx_i} < NUM_L);

    // Hit detection uses the registered (pre-write) slot contents.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            hit_s[i] = tick_i & armed_q[i] & (slot_time_q[i] == cur_time_i);
        end
    end

    // A hit disarms its slot; a same-edge write to that slot takes precedence.
    always_comb begin
        slot_time_d = slot_time_q;
        armed_d     = armed_q & ~hit_s;
        if (wr_ok_s) begin
            slot_time_d[wr_idx_i] = wr_time_i;
            armed_d[wr_idx_i]     = wr_arm_i;
        end else begin
            armed_d = armed_q & ~hit_s;
        end
    end

    // Slot registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            slot_time_q <= '{default: '0};
            armed_q     <= '0;
        end else begin
            slot_time_q <= slot_time_d;
            armed_q     <= armed_d;
        end
    end

    assign wr_ok_o = wr_ok_s;
    assign armed_o = armed_q;
    assign hit_o   = hit_s;

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot one-shot alarm engine with pending queue and ring FSM.
// Optional snooze path is enabled by defining ALARM_SNOOZE_EN.
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int NUM_ALARMS   = DEF_NUM_ALARMS,
    parameter int TIME_W       = DEF_TIME_W,
    parameter int RING_TIMEOUT = DEF_RING_TIMEOUT,
    parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
    parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE,
    localparam int IDX_W       = calc_idx_w(NUM_ALARMS)
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic                  tick_1s,
    input  logic [TIME_W-1:0]     cur_time,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TIME_W-1:0]     wr_time,
    input  logic                  wr_arm,
    input  logic                  dismiss,
    input  logic                  snooze,
    output logic [NUM_ALARMS-1:0] armed,
    output logic [NUM_ALARMS-1:0] pending,
    output logic                  ringing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [1:0]            state,
    output logic [1:0]            snooze_cnt,
    output logic                  missed
);

    localparam int RC_W = $clog2(RING_TIMEOUT + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_TIMEOUT - 1);

    alarm_state_e          state_q, state_d;
    logic [NUM_ALARMS-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]      ring_idx_q, ring_idx_d;
    logic [RC_W-1:0]       ring_cnt_q, ring_cnt_d;
    logic                  missed_q, missed_d;
    logic [NUM_ALARMS-1:0] hit_s;
    logic [NUM_ALARMS-1:0] wr_clr_s;
    logic [NUM_ALARMS-1:0] cand_s;
    logic [IDX_W-1:0]      first_idx_s;
    logic                  wr_ok_s;

`ifdef ALARM_SNOOZE_EN
    localparam int SC_W = $clog2(SNOOZE_TICKS + 1);
    localparam logic [SC_W-1:0] SNZ_LAST = SC_W'(SNOOZE_TICKS - 1);
    localparam logic [1:0]      SNZ_MAX  = 2'(MAX_SNOOZE);

    logic [SC_W-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]      snooze_cnt_q, snooze_cnt_d;
`else
    logic unused_snooze_s;
    assign unused_snooze_s = snooze;
`endif

    alarm_scheduler_slot_bank #(
        .NUM_ALARMS (NUM_ALARMS),
        .TIME_W     (TIME_W),
        .IDX_W      (IDX_W)
    ) u_slot_bank (
        .clk_i      (MCLK),
        .rst_n_i    (RESET),
        .tick_i     (tick_1s),
        .cur_time_i (cur_time),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_time_i  (wr_time),
        .wr_arm_i   (wr_arm),
        .wr_ok_o    (wr_ok_s),
        .armed_o    (armed),
        .hit_o      (hit_s)
    );

    // Queue candidates include same-edge hits; a write drops its slot's old pending bit.
    always_comb begin
        wr_clr_s = '0;
        if (wr_ok_s) begin
            wr_clr_s[wr_idx] = 1'b1;
        end else begin
            wr_clr_s = '0;
        end
        cand_s      = (pending_q & ~wr_clr_s) | hit_s;
        first_idx_s = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (cand_s[i]) begin
                first_idx_s = IDX_W'(i);
            end else begin
                first_idx_s = first_idx_s;
            end
        end
    end

    // Ring FSM next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = cand_s;
        ring_idx_d = ring_idx_q;
        ring_cnt_d = ring_cnt_q;
        missed_d   = wr_ok_s ? 1'b0 : missed_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cand_s != '0) begin
                    state_d                = ST_RINGING;
                    ring_idx_d             = first_idx_s;
                    pending_d[first_idx_s] = 1'b0;
                    ring_cnt_d             = '0;
`ifdef ALARM_SNOOZE_EN
                    snooze_cnt_d           = 2'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RINGING: begin
                if (dismiss) begin
                    state_d = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = ST_SNOOZED;
                    snz_cnt_d    = '0;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
`endif
                end else if (tick_1s) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d  = ST_IDLE;
                        missed_d = 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RC_W'(1);
                    end
                end else begin
                    state_d = ST_RINGING;
                end
            end
            ST_SNOOZED: begin
`ifdef ALARM_SNOOZE_EN
                if (dismiss) begin
                    state_d = ST_IDLE;
                end else if (tick_1s) begin
                    if (snz_cnt_q == SNZ_LAST) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + SC_W'(1);
                    end
                end else begin
                    state_d = ST_SNOOZED;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            ring_idx_q <= '0;
            ring_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ring_idx_q <= ring_idx_d;
            ring_cnt_q <= ring_cnt_d;
            missed_q   <= missed_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze counters.
    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            snz_cnt_q    <= '0;
            snooze_cnt_q <= 2'd0;
        end else begin
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
        end
    end

    assign snooze_cnt = snooze_cnt_q;
`else
    assign snooze_cnt = 2'd0;
`endif

    assign pending  = pending_q;
    assign ringing  = (state_q == ST_RINGING);
    assign ring_idx = ring_idx_q;
    assign state    = state_q;
    assign missed   = missed_q;

endmodule
